// File: rtl/mac512_pkg.sv
// Shared definitions for the MAC_512 datapath: default widths, the
// sequencer state encoding and the slice-counter width helper.
package mac512_pkg;

  localparam int WIDTH_DEFAULT = 512;
  localparam int SLICE_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n slices; never less than 1 so a single-slice
  // build still has a legal counter vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sub_slice_cla.sv
// SLICE-wide combinational subtract slice: {cout, d} = a + ~b + cin.
// Two-level carry lookahead: 4-bit groups with full internal lookahead,
// group generate/propagate chained between groups.
module sub_slice_cla #(
  parameter int SLICE = 128
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] d,
  output logic             cout
);

  localparam int GRP  = 4;
  localparam int NGRP = SLICE / GRP;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;

  // Subtraction is addition of the inverted subtrahend.
  assign g = a & ~b;
  assign p = a ^ ~b;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [GRP-1:0] gg;
      logic [GRP-1:0] pp;
      logic [GRP-1:0] lc;
      logic           ci;

      assign gg = g[gi*GRP +: GRP];
      assign pp = p[gi*GRP +: GRP];
      assign ci = grp_c[gi];

      assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p[gi] = &pp;

      // Carries into each bit of the group, all from the group carry-in.
      assign lc[0] = ci;
      assign lc[1] = gg[0] | (pp[0] & ci);
      assign lc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      assign lc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & ci);

      assign d[gi*GRP +: GRP] = pp ^ lc;
    end
  endgenerate

  // Group carry chain across the slice.
  always_comb begin
    logic c;
    c        = cin;
    grp_c    = '0;
    grp_c[0] = c;
    for (int i = 0; i < NGRP; i++) begin
      c          = grp_g[i] | (grp_p[i] & c);
      grp_c[i+1] = c;
    end
  end

  assign cout = grp_c[NGRP];

endmodule

// File: rtl/seq_sub512.sv
// Multi-cycle WIDTH-bit subtractor D = A - B, one SLICE-wide lookahead
// slice per cycle with the borrow carried between cycles.
// Optional macro SEQ_SUB_SIGNED_OVF_EN adds the registered ovf output.
module seq_sub512
  import mac512_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             borrow
`ifdef SEQ_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = clog2(NSLICE);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   res_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               borrow_reg;

  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_d;
  logic               slice_c;
  logic               accept;
  logic               step;
  logic               last;

  assign slice_a = a_reg[cnt_reg*SLICE +: SLICE];
  assign slice_b = b_reg[cnt_reg*SLICE +: SLICE];

  sub_slice_cla #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .d    (slice_d),
    .cout (slice_c)
  );

  assign accept = en & in_valid & (state_reg == IDLE);
  assign step   = en & (state_reg == RUN);
  assign last   = (cnt_reg == CNT_W'(NSLICE - 1));

  // State register; en=0 freezes the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else if (en) state_reg <= state_next;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and one slice of subtraction per enabled RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      carry_reg  <= 1'b1;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
    end else if (accept) begin
      a_reg     <= A_in;
      b_reg     <= B_in;
      carry_reg <= 1'b1;
      cnt_reg   <= '0;
    end else if (step) begin
      res_reg[cnt_reg*SLICE +: SLICE] <= slice_d;
      carry_reg <= slice_c;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      if (last) borrow_reg <= ~slice_c;
    end
  end

  assign res    = res_reg;
  assign borrow = borrow_reg;

`ifdef SEQ_SUB_SIGNED_OVF_EN
  logic ovf_reg;

  // Signed overflow: operand signs differ and the result sign leaves A's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_reg <= 1'b0;
    else if (step && last)
      ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                 (slice_d[SLICE-1] != a_reg[WIDTH-1]);
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: doc/seq_sub512.md
Name: seq_sub512

Overview:
- Multi-cycle 512-bit subtractor for the MAC_512 datapath; computes D = A − B (two's complement).
- Complements the registered 128-bit CLA adder stage: reuses one 128-bit carry-lookahead slice over four cycles with borrow chaining instead of instantiating 512-bit hardware.
- Sits between the accumulator and result formatting, used for accumulator correction and compare.
- valid/ready handshake on both sides.

Parameters:
- WIDTH, 512, operand/result width; must be an integer multiple of SLICE.
- SLICE, 128, width of the internal CLA slice processed per cycle.
- NSLICE, WIDTH/SLICE (derived localparam, not overridable), number of RUN cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when 0 all state, counters and registers hold.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A_in  input  WIDTH  minuend.
- B_in  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- res  output  WIDTH  A − B modulo 2^WIDTH, registered.
- borrow  output  1  1 when A < B unsigned; registered, valid with out_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; slice counter=0; carry=1; A/B/result registers=0; in_ready=1; out_valid=0; res=0; borrow=0.
- Reset asserted mid-operation: the operation is discarded and the block returns to IDLE immediately.
- FSM states:
  - IDLE: in_ready=1. On an edge with en & in_valid: capture A_in and B_in, set carry=1, set cnt=0, go to RUN.
  - RUN: in_ready=0. Each edge with en computes one slice: {c, d} = A[cnt*SLICE +: SLICE] + ~B[cnt*SLICE +: SLICE] + carry. Store d into the result slice cnt; carry<=c; cnt<=cnt+1. On the edge processing cnt=NSLICE−1: borrow<=~c, go to DONE.
  - DONE: out_valid=1, in_ready=0. On an edge with en & out_ready: go to IDLE, out_valid drops.
- Latency: operands accepted at edge T; out_valid high after edge T+NSLICE (T+4 at default); this assumes en stays high.
- Throughput: one operation per NSLICE+2 cycles minimum. There is no acceptance in DONE, so there is no same-cycle turnaround.
- en=0 in any state: full freeze. Outputs hold and no handshake completes. in_ready and out_valid still reflect the state.
- Once out_valid is high, res and borrow are stable until the handshake completes.
- Ready/valid pair in one cycle while en=0: not a transfer.
- Width rules:
  - All arithmetic is unsigned, modulo 2^WIDTH.
  - The final carry-out is inverted to give borrow. The signed interpretation is left to the consumer.
- Result register bits of unprocessed slices keep their stale values during RUN. They are not observable because out_valid=0.

Optional Feature:
- Macro: SEQ_SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit, registered, reset 0), valid with out_valid. ovf = signed overflow of the full-width subtract = (A[MSB] != B[MSB]) & (res[MSB] != A[MSB]).
- Undefined: the port is absent and no logic is generated; all other behaviour is identical.

Decomposition:
- Shared package mac512_pkg:
  - WIDTH_DEFAULT=512 and SLICE_DEFAULT=128.
  - FSM state enum (IDLE, RUN, DONE), 2-bit encoding.
  - Slice-counter width function clog2(NSLICE).
- Sub-module: sub_slice_cla. SLICE-wide combinational carry-lookahead block computing A + ~B + cin → {cout, d}, built on the existing CLA structure. The top instantiates it once.

Test Plan:
- A=5, B=3 → after 4 RUN edges, out_valid=1, res=2, borrow=0. Check in_ready=0 from the accept edge until the handshake completes.
- A=0, B=1 → res=all ones (2^512−1), borrow=1. Checks borrow propagation through all four slices.
- A=2^128, B=1 → res=2^128−1 (slice0=all ones, slices1–3=0), borrow=0. Checks the inter-slice borrow at cnt=0→1.
- Hold out_ready=0 for 10 cycles in DONE, and pulse in_valid with new operands → res/borrow stable, second operand not accepted. Assert out_ready → IDLE next edge, then the second operand is accepted.
- en=0 for 3 cycles at cnt=2, A=2^511, B=2^510 → result delayed by exactly 3 cycles, res=2^510. With SEQ_SUB_SIGNED_OVF_EN, A=2^511 (most negative), B=1 → ovf=1, res=2^511−1.
- rst_n low mid-RUN (cnt=1) → immediately in_ready=1, out_valid=0, res=0. A new operand pair after release completes normally.
